// File: rtl/psum_accum_ctrl.sv
`timescale 1ns/1ps
// Partial-sum accumulator: read-modify-write of psum BRAM words over a two-stage
// pipeline with same-address forwarding, optional saturation and a host bypass port.
module psum_accum_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BYTE   = 4,
    parameter int REG_WIDTH  = 32,
    parameter int SATURATE   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REG_WIDTH-1:0]         i_conf_ctrl,
    input  logic [REG_WIDTH-1:0]         i_conf_outputsize,
    output logic [REG_WIDTH-1:0]         o_conf_status,
    input  logic                         i_psum_valid,
    output logic                         o_psum_ready,
    input  logic [ADDR_WIDTH-1:0]        i_psum_addr,
    input  logic signed [DATA_WIDTH-1:0] i_psum_data,
    input  logic [ADDR_WIDTH-1:0]        bram_addr_a,
    input  logic [DATA_WIDTH-1:0]        bram_wrdata_a,
    output logic [DATA_WIDTH-1:0]        bram_rddata_a,
    input  logic                         bram_en_a,
    input  logic [NUM_BYTE-1:0]          bram_we_a,
    output logic [ADDR_WIDTH-1:0]        mem_raddr,
    input  logic [DATA_WIDTH-1:0]        mem_odat,
    output logic [ADDR_WIDTH-1:0]        mem_waddr,
    output logic [DATA_WIDTH-1:0]        mem_idat,
    output logic [NUM_BYTE-1:0]          mem_wren
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2, HOST = 2'd3} state_t;

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                       state, state_nxt;
    logic                         ctrl_en, ctrl_host, ctrl_ovw;
    logic                         xfer_p0;
    logic                         vld_p1, fwd_p1, last_p1;
    logic [ADDR_WIDTH-1:0]        addr_p1;
    logic signed [DATA_WIDTH-1:0] data_p1, operand_p1, wdata_p1;
    logic signed [DATA_WIDTH-1:0] prev_wdata_p2;
    logic [DATA_WIDTH:0]          add_res_p1;
    logic                         sat_now_p1;
    logic [REG_WIDTH-1:0]         cnt_q;
    logic                         done_q, sat_q;
    logic                         unused_ctrl_bits;

    // Returns {overflow_flag, result}; the flag is only raised when clamping is enabled.
    function automatic logic [DATA_WIDTH:0] add_sat(input logic signed [DATA_WIDTH-1:0] a,
                                                    input logic signed [DATA_WIDTH-1:0] b);
        logic signed [DATA_WIDTH:0] wide;
        logic                       ovf;
        wide = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        ovf  = wide[DATA_WIDTH] ^ wide[DATA_WIDTH-1];
        if ((SATURATE != 0) && ovf)
            return {1'b1, (a[DATA_WIDTH-1] ? SAT_MIN : SAT_MAX)};
        return {1'b0, wide[DATA_WIDTH-1:0]};
    endfunction

    assign ctrl_en          = i_conf_ctrl[0];
    assign ctrl_host        = i_conf_ctrl[4];
    assign ctrl_ovw         = i_conf_ctrl[8];
    assign unused_ctrl_bits = ^{i_conf_ctrl[REG_WIDTH-1:9], i_conf_ctrl[7:5], i_conf_ctrl[3:1]};

    assign o_psum_ready = (state == ACCUM);
    assign xfer_p0      = i_psum_valid & o_psum_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // DRAIN lasts one cycle: ready is low there, so the S1 write in flight is the last one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ctrl_host) state_nxt = HOST;
                     else if (ctrl_en) state_nxt = ACCUM;
            ACCUM:   if (ctrl_host || !ctrl_en) state_nxt = DRAIN;
            DRAIN:   state_nxt = ctrl_host ? HOST : IDLE;
            HOST:    if (!ctrl_host) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- S0 -> S1 boundary ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_p1 <= 1'b0;
        else      vld_p1 <= xfer_p0;
    end

    always_ff @(posedge clk) begin
        if (xfer_p0) begin
            addr_p1 <= i_psum_addr;
            data_p1 <= i_psum_data;
            fwd_p1  <= vld_p1 && (i_psum_addr == addr_p1);
            last_p1 <= (cnt_q == i_conf_outputsize);
        end
        if (vld_p1) prev_wdata_p2 <= wdata_p1;
    end

    // ---- S1: operand select, add, write ----
    always_comb begin
        operand_p1 = fwd_p1 ? prev_wdata_p2 : $signed(mem_odat);
        add_res_p1 = add_sat(operand_p1, data_p1);
        if (ctrl_ovw) begin
            wdata_p1   = data_p1;
            sat_now_p1 = 1'b0;
        end else begin
            wdata_p1   = add_res_p1[DATA_WIDTH-1:0];
            sat_now_p1 = add_res_p1[DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            sat_q  <= 1'b0;
        end else if (state == IDLE && !ctrl_en) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            if (xfer_p0)               cnt_q  <= cnt_q + 1'b1;
            if (vld_p1 && last_p1)     done_q <= 1'b1;
            if (vld_p1 && sat_now_p1)  sat_q  <= 1'b1;
        end
    end

    // Host and pipeline never overlap: HOST is only reached after DRAIN or from IDLE.
    always_comb begin
        mem_raddr     = '0;
        mem_waddr     = '0;
        mem_idat      = '0;
        mem_wren      = '0;
        bram_rddata_a = '0;
        if (state == HOST) begin
            mem_raddr     = bram_addr_a;
            mem_waddr     = bram_addr_a;
            mem_idat      = bram_wrdata_a;
            mem_wren      = bram_en_a ? bram_we_a : '0;
            bram_rddata_a = mem_odat;
        end else begin
            if (xfer_p0) mem_raddr = i_psum_addr;
            if (vld_p1) begin
                mem_waddr = addr_p1;
                mem_idat  = wdata_p1;
                mem_wren  = '1;
            end
        end
    end

    always_comb begin
        o_conf_status    = '0;
        o_conf_status[0] = vld_p1 | (state == DRAIN);
        o_conf_status[1] = done_q | (vld_p1 & last_p1);
        o_conf_status[2] = (state == HOST);
        o_conf_status[3] = sat_q | (vld_p1 & sat_now_p1);
    end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
`timescale 1ns/1ps
// Bench for psum_accum_ctrl: BRAM model, scoreboard of expected writes and a
// reference accumulator memory computed with plain integer arithmetic.
module tb_psum_accum_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        ctrl, outsize, status;
    logic               psum_valid, psum_ready;
    logic [31:0]        psum_addr;
    logic signed [31:0] psum_data;
    logic [31:0]        h_addr, h_wdata, h_rdata;
    logic               h_en;
    logic [3:0]         h_we;
    logic [31:0]        mem_raddr, mem_odat, mem_waddr, mem_idat;
    logic [3:0]         mem_wren;

    always #5 clk = ~clk;

    psum_accum_ctrl dut (
        .clk(clk), .rst(rst), .i_conf_ctrl(ctrl), .i_conf_outputsize(outsize),
        .o_conf_status(status), .i_psum_valid(psum_valid), .o_psum_ready(psum_ready),
        .i_psum_addr(psum_addr), .i_psum_data(psum_data), .bram_addr_a(h_addr),
        .bram_wrdata_a(h_wdata), .bram_rddata_a(h_rdata), .bram_en_a(h_en), .bram_we_a(h_we),
        .mem_raddr(mem_raddr), .mem_odat(mem_odat), .mem_waddr(mem_waddr),
        .mem_idat(mem_idat), .mem_wren(mem_wren)
    );

    // BRAM model: 16 words, read-first, one cycle read latency, byte enables.
    logic [31:0] mem [16];
    logic        mem_clr, pl_en;
    logic [3:0]  pl_addr;
    logic [31:0] pl_data;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_odat <= mem[int'(mem_raddr % 32'd16)];
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (pl_en) mem[pl_addr] <= pl_data;
            for (int b = 0; b < 4; b++)
                if (mem_wren[b]) mem[int'(mem_waddr % 32'd16)][8*b +: 8] <= mem_idat[8*b +: 8];
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wren;
        bit          chk;
        bit          done;
        bit          sat;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [16];
    int          ref_cnt;
    bit          ref_sat;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Signed add with clamping to the 32-bit range, done in 64-bit integer arithmetic.
    function automatic logic [31:0] ref_add(input logic [31:0] old, input logic [31:0] p, output bit s);
        longint sum;
        sum = longint'($signed(old)) + longint'($signed(p));
        s = 1'b0;
        if (sum > 64'sd2147483647) begin
            s = 1'b1;
            return 32'h7FFF_FFFF;
        end
        if (sum < -64'sd2147483648) begin
            s = 1'b1;
            return 32'h8000_0000;
        end
        return sum[31:0];
    endfunction

    always @(negedge clk) begin
        exp_t m;
        if (rst === 1'b1 && mem_wren !== 4'h0) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: addr %h data %h wren %h", mem_waddr, mem_idat, mem_wren);
            end else begin
                m = q.pop_front();
                if (mem_waddr !== m.addr || mem_idat !== m.data || mem_wren !== m.wren || cyc != m.cyc ||
                    (m.chk && (status[1] !== m.done || status[3] !== m.sat))) begin
                    fails++;
                    $display("FAIL write: got addr %h data %h wren %h cyc %0d done %b sat %b, expected addr %h data %h wren %h cyc %0d done %b sat %b",
                             mem_waddr, mem_idat, mem_wren, cyc, status[1], status[3],
                             m.addr, m.data, m.wren, m.cyc, m.done, m.sat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input bit push);
        exp_t e;
        bit   s;
        psum_valid = 1'b1; psum_addr = a; psum_data = d;
        @(negedge clk);
        chk("ready_in_accum", {31'd0, psum_ready}, 32'd1);
        tick();
        psum_valid = 1'b0;
        if (push) begin
            s = 1'b0;
            if (ctrl[8]) e.data = d;
            else         e.data = ref_add(ref_mem[a[3:0]], d, s);
            ref_mem[a[3:0]] = e.data;
            ref_cnt++;
            if (s) ref_sat = 1'b1;
            e.addr = a; e.wren = 4'hF; e.chk = 1'b1;
            e.done = (ref_cnt >= int'(outsize) + 1);
            e.sat  = ref_sat;
            e.cyc  = cyc;
            q.push_back(e);
        end
    endtask

    task automatic host_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        exp_t e;
        h_en = 1'b1; h_we = we; h_addr = a; h_wdata = d;
        for (int b = 0; b < 4; b++)
            if (we[b]) ref_mem[a[3:0]][8*b +: 8] = d[8*b +: 8];
        e.addr = a; e.data = d; e.wren = we; e.chk = 1'b0; e.done = 1'b0; e.sat = 1'b0; e.cyc = cyc;
        q.push_back(e);
        tick();
        h_en = 1'b0; h_we = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        rst = 1'b0; mem_clr = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        ref_cnt = 0; ref_sat = 1'b0;
        // Inputs wiggling during reset must not reach any output.
        ctrl = 32'h11; outsize = 0; psum_valid = 1'b1; psum_addr = 3; psum_data = 9;
        h_en = 1'b1; h_we = 4'hF; h_addr = 5; h_wdata = 32'h1234;
        repeat (3) tick();
        chk("rst_status", status, 32'h0);
        chk("rst_ready", {31'd0, psum_ready}, 32'h0);
        chk("rst_wren", {28'd0, mem_wren}, 32'h0);
        chk("rst_raddr", mem_raddr, 32'h0);
        chk("rst_waddr", mem_waddr, 32'h0);
        chk("rst_idat", mem_idat, 32'h0);
        chk("rst_rddata", h_rdata, 32'h0);
        ctrl = 0; psum_valid = 1'b0; h_en = 1'b0; h_we = 4'h0;
        mem_clr = 1'b0; rst = 1'b1;
        tick();

        // Directed accumulation cases
        outsize = 3; ctrl = 32'h1;
        tick();
        chk("accum_status_idle_pipe", status, 32'h0);
        send(3, 5, 1);
        preload(7, 10);
        send(7, 1, 1);
        send(7, 2, 1);
        send(7, 3, 1);
        tick();
        chk("mem7_after_b2b", mem[7], 32'd16);
        chk("done_sticky", {31'd0, status[1]}, 32'd1);
        ctrl = 32'h101;
        preload(2, 99);
        send(2, 4, 1);
        tick();
        chk("mem2_overwrite", mem[2], 32'd4);
        ctrl = 32'h1;
        preload(4, 32'h7FFF_FFF0);
        send(4, 32'h20, 1);
        tick();
        chk("sat_pos_value", mem[4], 32'h7FFF_FFFF);
        chk("sat_sticky", {31'd0, status[3]}, 32'd1);
        preload(5, 32'h8000_0010);
        send(5, -32'sd32, 1);
        tick();
        chk("sat_neg_value", mem[5], 32'h8000_0000);

        // ACCUM -> DRAIN -> HOST
        ctrl = 32'h11;
        tick();
        chk("drain_ready", {31'd0, psum_ready}, 32'd0);
        chk("drain_busy", {31'd0, status[0]}, 32'd1);
        chk("drain_host_active", {31'd0, status[2]}, 32'd0);
        tick();
        chk("host_active", {31'd0, status[2]}, 32'd1);
        chk("host_busy", {31'd0, status[0]}, 32'd0);
        h_en = 1'b1; h_we = 4'h0; h_addr = 7;
        @(negedge clk);
        chk("host_raddr", mem_raddr, 32'd7);
        chk("host_read_nowrite", {28'd0, mem_wren}, 32'h0);
        tick();
        chk("host_read7", h_rdata, 32'd16);
        psum_valid = 1'b1; psum_addr = 6; psum_data = 1;
        host_write(6, 32'hCAFE_F00D, 4'hF);
        host_write(6, 32'h1111_2222, 4'h3);
        h_en = 1'b0; h_we = 4'hF; h_addr = 6;
        @(negedge clk);
        chk("host_ready_low", {31'd0, psum_ready}, 32'd0);
        chk("host_en_low_nowrite", {28'd0, mem_wren}, 32'h0);
        tick();
        psum_valid = 1'b0; h_we = 4'h0; h_en = 1'b1;
        tick();
        tick();
        chk("host_read6", h_rdata, ref_mem[6]);
        h_en = 1'b0;

        // HOST -> IDLE with enable low clears the sticky flags
        ctrl = 32'h0;
        repeat (2) tick();
        chk("idle_cleared", status, 32'h0);
        ref_cnt = 0; ref_sat = 1'b0;

        // Randomized accumulation
        outsize = 120; ctrl = 32'h1;
        tick();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 7) begin
                if ($urandom_range(0, 7) == 0) d = $urandom;
                else                           d = $urandom_range(0, 2000) - 32'd1000;
                send($urandom_range(8, 15), d, 1);
            end else begin
                tick();
            end
        end
        ctrl = 32'h11;
        repeat (2) tick();
        for (int a = 8; a < 16; a++) begin
            h_en = 1'b1; h_addr = a;
            tick();
            chk("host_readback", h_rdata, ref_mem[a]);
        end
        h_en = 1'b0;
        ctrl = 32'h0;
        repeat (2) tick();
        ctrl = 32'h1;
        tick();

        // Reset while a write is in S1
        send(9, 77, 0);
        rst = 1'b0;
        #1;
        chk("midrst_wren", {28'd0, mem_wren}, 32'h0);
        chk("midrst_waddr", mem_waddr, 32'h0);
        chk("midrst_idat", mem_idat, 32'h0);
        chk("midrst_status", status, 32'h0);
        chk("midrst_ready", {31'd0, psum_ready}, 32'h0);
        ctrl = 32'h0;
        tick();
        chk("midrst_mem9", mem[9], ref_mem[9]);
        rst = 1'b1;
        tick();
        chk("post_rst_status", status, 32'h0);
        chk("post_rst_ready", {31'd0, psum_ready}, 32'h0);
        chk("post_rst_mem9", mem[9], ref_mem[9]);
        ctrl = 32'h1;
        tick();
        chk("post_rst_accum", {31'd0, psum_ready}, 32'h1);
        ctrl = 32'h0;
        repeat (3) tick();

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL pending_writes: %0d expected writes never seen, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
